// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch
//   Inter-stage pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) built as a
//   valid/ready handshake over a 2-entry skid buffer. A downstream stall
//   never drops or duplicates an entry; flush squashes everything held.
//   When no valid entry is at the output the latch presents a NOP bubble:
//   out_ctrl is all zero and out_instr is NOP_INSTR.
//
// Configuration macro:
//   PIPE_SKID_LATCH_STATS_EN  - when defined, builds saturating stall/bubble
//                               counters; otherwise both outputs are tied to 0.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset (priority over flush and fires)
//   flush      squash both held entries; a same-cycle input is discarded
//   in_valid   upstream presents an entry
//   in_ready   latch can accept (function of state only)
//   in_data    payload           (DATA_W)
//   in_ctrl    control bundle    (CTRL_W)
//   in_instr   instruction       (INSTR_W)
//   out_valid  head entry valid
//   out_ready  downstream accepts
//   out_data   head payload (stale contents during a bubble)
//   out_ctrl   head control, 0 during a bubble
//   out_instr  head instruction, NOP_INSTR during a bubble
//   stall_cnt  cycles with out_valid && !out_ready (stats build only)
//   bubble_cnt cycles with !out_valid (stats build only)

module pipe_skid_latch #(
    parameter int                 DATA_W    = 64,
    parameter int                 CTRL_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
    parameter int                 STAT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [INSTR_W-1:0] out_instr,
    output logic [STAT_W-1:0]  stall_cnt,
    output logic [STAT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic in_fire;
    logic out_fire;

    // Head (H) is always what the output shows; skid (S) catches the one
    // entry accepted while the head is stalled.
    logic [DATA_W-1:0]  h_data_q;
    logic [CTRL_W-1:0]  h_ctrl_q;
    logic [INSTR_W-1:0] h_instr_q;
    logic [DATA_W-1:0]  s_data_q;
    logic [CTRL_W-1:0]  s_ctrl_q;
    logic [INSTR_W-1:0] s_instr_q;

    logic load_h_in;
    logic load_h_skid;
    logic load_s;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) state_d = ONE;
            end
            ONE: begin
                if (in_fire && !out_fire)      state_d = FULL;
                else if (!in_fire && out_fire) state_d = EMPTY;
            end
            FULL: begin
                if (out_fire) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        out_data  = h_data_q;
        out_ctrl  = out_valid ? h_ctrl_q  : '0;
        out_instr = out_valid ? h_instr_q : NOP_INSTR;
    end

    // Payload moves are suppressed under flush: whatever is loaded would be
    // squashed anyway, and skipping the load keeps the stale head stable.
    assign load_h_in   = !flush && in_fire &&
                         ((state_q == EMPTY) || ((state_q == ONE) && out_fire));
    assign load_s      = !flush && in_fire && (state_q == ONE) && !out_fire;
    assign load_h_skid = !flush && (state_q == FULL) && out_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_data_q  <= '0;
            h_ctrl_q  <= '0;
            h_instr_q <= NOP_INSTR;
            s_data_q  <= '0;
            s_ctrl_q  <= '0;
            s_instr_q <= NOP_INSTR;
        end else begin
            if (load_h_in) begin
                h_data_q  <= in_data;
                h_ctrl_q  <= in_ctrl;
                h_instr_q <= in_instr;
            end else if (load_h_skid) begin
                h_data_q  <= s_data_q;
                h_ctrl_q  <= s_ctrl_q;
                h_instr_q <= s_instr_q;
            end
            if (load_s) begin
                s_data_q  <= in_data;
                s_ctrl_q  <= in_ctrl;
                s_instr_q <= in_instr;
            end
        end
    end

`ifdef PIPE_SKID_LATCH_STATS_EN
    logic [STAT_W-1:0] stall_q;
    logic [STAT_W-1:0] bubble_q;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Counters ignore flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready) stall_q <= sat_inc(stall_q);
            if (!out_valid)              bubble_q <= sat_inc(bubble_q);
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_latch.sv
// tb_pipe_skid_latch
//   Randomized and directed stimulus for pipe_skid_latch, checked against a
//   queue-based reference: the latch is a FIFO of depth 2 whose head is the
//   output, emptied by flush and rst.

module tb_pipe_skid_latch;

    localparam int              DATA_W  = 64;
    localparam int              CTRL_W  = 16;
    localparam int              INSTR_W = 16;
    localparam int              STAT_W  = 4;
    localparam logic [15:0]     NOP     = 16'h0800;
    localparam int              SAT_MAX = (1 << STAT_W) - 1;
`ifdef PIPE_SKID_LATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0]  in_data, out_data;
    logic [CTRL_W-1:0]  in_ctrl, out_ctrl;
    logic [INSTR_W-1:0] in_instr, out_instr;
    logic [STAT_W-1:0]  stall_cnt, bubble_cnt;

    pipe_skid_latch #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .INSTR_W(INSTR_W),
        .NOP_INSTR(NOP), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_instr(out_instr),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0]  d;
        logic [CTRL_W-1:0]  c;
        logic [INSTR_W-1:0] i;
    } ent_t;

    ent_t mq[$];
    int   m_stall, m_bubble;
    bit   model_ok;
    int   n_tests, n_fail;
    bit   last_fire;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", out_data, mq[0].d);
            chk("out_ctrl", 64'(out_ctrl), 64'(mq[0].c));
            chk("out_instr", 64'(out_instr), 64'(mq[0].i));
        end else begin
            chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
            chk("bubble_instr", 64'(out_instr), 64'(NOP));
        end
        chk("stall_cnt", 64'(stall_cnt), STATS ? 64'(m_stall) : 64'd0);
        chk("bubble_cnt", 64'(bubble_cnt), STATS ? 64'(m_bubble) : 64'd0);
    endtask

    // One clock: drive at negedge, check settled outputs, advance model at
    // posedge, return at the following negedge.
    task automatic cycle(input bit r, input bit f, input bit iv,
                         input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic [INSTR_W-1:0] i, input bit ordy);
        bit inf, outf;
        rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c;
        in_instr = i; out_ready = ordy;
        #1;
        if (model_ok) check_outputs();
        inf  = iv && (mq.size() < 2);
        outf = (mq.size() > 0) && ordy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_stall  = 0;
            m_bubble = 0;
            model_ok = 1'b1;
        end else begin
            if (mq.size() > 0 && !ordy && m_stall < SAT_MAX) m_stall++;
            if (mq.size() == 0 && m_bubble < SAT_MAX) m_bubble++;
            if (outf) void'(mq.pop_front());
            if (f) mq.delete();
            else if (inf) mq.push_back('{d: d, c: c, i: i});
        end
        last_fire = inf && !f;
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy);
    endtask

    task automatic push(input logic [INSTR_W-1:0] i, input bit ordy);
        cycle(1'b0, 1'b0, 1'b1, {48'h0, i} ^ 64'hA5A5_0000_0000_0000,
              ~i, i, ordy);
    endtask

    initial begin
        logic               cv;
        logic [DATA_W-1:0]  cd;
        logic [CTRL_W-1:0]  cc;
        logic [INSTR_W-1:0] ci;
        bit                 fl;
        n_tests = 0; n_fail = 0; model_ok = 1'b0; m_stall = 0; m_bubble = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0; in_instr = '0;
        @(negedge clk);

        // Reset state and bubble count
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'h0800);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk("idle3_bubble_cnt", 64'(bubble_cnt), STATS ? 64'd3 : 64'd0);

        // Streaming
        push(16'd1, 1'b1);
        chk("stream1", 64'(out_instr), 64'd1);
        push(16'd2, 1'b1);
        chk("stream2", 64'(out_instr), 64'd2);
        push(16'd3, 1'b1);
        chk("stream3", 64'(out_instr), 64'd3);
        chk("stream_in_ready", 64'(in_ready), 64'd1);
        idle(1'b1);

        // Skid: A, B accepted while stalled, C held until space frees
        push(16'hA, 1'b0);
        push(16'hB, 1'b0);
        chk("skid_full_ready", 64'(in_ready), 64'd0);
        push(16'hC, 1'b0);
        chk("skid_head_A", 64'(out_instr), 64'hA);
        push(16'hC, 1'b1);
        chk("skid_head_B", 64'(out_instr), 64'hB);
        push(16'hC, 1'b1);
        chk("skid_head_C", 64'(out_instr), 64'hC);
        idle(1'b1);
        chk("skid_drained", 64'(out_valid), 64'd0);

        // Flush in FULL with a same-cycle input
        push(16'h11, 1'b0); push(16'h12, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 64'h55, 16'hFFFF, 16'h13, 1'b0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_instr", 64'(out_instr), 64'(NOP));

        // rst beats flush and in_valid in FULL
        push(16'h21, 1'b0); push(16'h22, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 64'h77, 16'hFFFF, 16'h23, 1'b1);
        chk("rstfl_out_valid", 64'(out_valid), 64'd0);
        chk("rstfl_in_ready", 64'(in_ready), 64'd1);
        chk("rstfl_instr", 64'(out_instr), 64'(NOP));
        chk("rstfl_stall", 64'(stall_cnt), 64'd0);

        // Saturation of stall_cnt
        push(16'h31, 1'b0);
        for (int k = 0; k < 20; k++) idle(1'b0);
        chk("stall_sat", 64'(stall_cnt), STATS ? 64'hF : 64'd0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Random traffic; upstream holds an offered entry until it is taken
        cv = 1'b0; cd = '0; cc = '0; ci = '0;
        for (int n = 0; n < 400; n++) begin
            fl = ($urandom_range(15) == 0);
            cycle(($urandom_range(63) == 0), fl, cv, cd, cc, ci,
                  ($urandom_range(1) == 1));
            if (!cv || last_fire || fl || rst) begin
                cv = ($urandom_range(3) != 0);
                cd = {$urandom, $urandom};
                cc = 16'($urandom);
                ci = 16'($urandom);
            end
        end
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
